adder_accum_stream: RTL and testbench
=====================================

Name: adder_accum_stream

Overview:
- Streaming accumulator directly downstream of the 6-bit prefix `adder`.
- Consumes a framed stream of WIDTH-bit operands under valid/ready and sums each frame in the `adder` instance.
- The instance's cout feeds an EXT-bit upper counter, giving a wide sum.
- Presents one registered result per frame (sum, beat count, overflow) under valid/ready to the next stage.

Parameters:
- WIDTH, 6, operand width; also the width of the `adder` instance.
- EXT, 4, upper extension bits; accumulator width ACC_W = WIDTH+EXT.
- CNT_W, 5, width of the per-frame beat counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  WIDTH  unsigned operand.
- in_last  input  1  beat is the final beat of its frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH+EXT  frame sum, modulo 2^ACC_W.
- out_count  output  CNT_W  beats in the frame, saturating.
- out_ovf  output  1  sticky: the frame sum exceeded 2^ACC_W-1.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async assert, deassertion sampled on clk):
  - State goes to IDLE.
  - acc_lo, acc_hi, count and ovf clear to 0.
  - out_valid = 0, in_ready = 0 while rst is high.
  - A partial frame in progress is discarded.
- States: IDLE (accumulator zero, no frame open), ACCUM (frame open), HOLD (result presented).
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. out_valid = 1 only in HOLD.
- A beat is accepted when in_valid && in_ready. On acceptance:
  - The `adder` computes a = acc_lo, b = in_data.
  - acc_lo <= s.
  - acc_hi <= acc_hi + cout, wrapping modulo 2^EXT.
  - If cout=1 and acc_hi is all-ones, ovf <= 1. ovf is sticky until the frame is released.
  - count <= count+1, saturating at 2^CNT_W-1.
- Transitions:
  - IDLE -> ACCUM on an accepted beat with in_last=0.
  - IDLE -> HOLD on an accepted beat with in_last=1 (single-beat frame).
  - ACCUM -> HOLD on an accepted beat with in_last=1.
  - ACCUM stays in ACCUM when no beat is accepted. in_valid gaps are legal and change nothing.
  - HOLD -> IDLE when out_ready=1. In the same edge acc_lo, acc_hi, count and ovf clear to 0.
- Latency: result is valid in the cycle after the last beat is accepted.
- Throughput: one bubble per frame, because in_ready is low in HOLD. No beat is accepted on the release edge.
- Output hold: out_sum = {acc_hi, acc_lo}, plus out_count and out_ovf, are driven straight from registers. They must remain stable while out_valid=1 and out_ready=0.
- When out_valid=0, outputs show the live accumulator. Their content is a don't-care for downstream.
- in_data and in_last are ignored when in_ready=0.
- Unsigned arithmetic only; no signed interpretation.
- Reset mid-HOLD drops the pending result: out_valid falls immediately (asynchronously).

Decomposition:
- Shared package holds:
  - State enum {IDLE, ACCUM, HOLD}.
  - Localparam ACC_W = WIDTH+EXT.
  - Saturation constant CNT_MAX = 2^CNT_W-1.
- One sub-module, the existing combinational `adder`, instantiated with WIDTH. All carry logic for the low part lives there.
- Upper-counter increment, FSM and handshake stay in this module.

Test Plan:
- Single beat: in_data=42, in_last=1, out_ready=1.
  -> next cycle out_valid=1, out_sum=42, out_count=1, out_ovf=0. IDLE the cycle after.
- Carry into extension: beats 63, 1 (last).
  -> out_sum=64 (acc_lo=0, acc_hi=1), out_count=2, out_ovf=0.
- Overflow: 17 beats of 63, last on the 17th.
  -> out_sum=47 (1071-1024), out_count=17, out_ovf=1.
- Backpressure: frame 5,6 (last), out_ready=0 for 5 cycles, in_valid held high with data=9.
  -> in_ready=0 and out_sum=11 stable throughout.
  -> after out_ready=1: IDLE, then beat 9 accepted next cycle. A following single-beat frame gives out_sum=9.
- Gaps and saturation: 40 beats of 1 with in_valid toggling every cycle.
  -> out_sum=40, out_count=31 (saturated), out_ovf=0.
- Async reset mid-frame: beats 10, 20, then rst pulse between edges.
  -> outputs 0 immediately, in_ready=0 during rst.
  -> next frame 3 (last) gives out_sum=3, out_count=1.

Source files
------------

// File: rtl/adder_accum_stream_pkg.sv
// Shared types and default sizes for the streaming frame accumulator.
package adder_accum_stream_pkg;

  localparam int DEF_WIDTH = 6;
  localparam int DEF_EXT   = 4;
  localparam int DEF_CNT_W = 5;
  localparam int ACC_W     = DEF_WIDTH + DEF_EXT;
  localparam int CNT_MAX   = (1 << DEF_CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/adder.sv
// Combinational Kogge-Stone prefix adder: s = a + b, carry out on cout.
module adder #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g_n;
  logic [WIDTH-1:0] p_n;

  // After the prefix levels g[i] is the carry out of bit i.
  always_comb begin
    g   = a & b;
    p   = a ^ b;
    g_n = g;
    p_n = p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < WIDTH; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    s    = (a ^ b) ^ {g[WIDTH-2:0], 1'b0};
    cout = g[WIDTH-1];
  end

endmodule

// File: rtl/adder_accum_stream.sv
// Sums each valid/ready framed operand stream into a wide accumulator and
// presents one held result (sum, beat count, overflow) per frame.
module adder_accum_stream
  import adder_accum_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int EXT   = DEF_EXT,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH+EXT-1:0]   out_sum,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_ovf
);

  // Handshake: a beat moves on a rising edge where in_valid && in_ready;
  // a result moves on a rising edge where out_valid && out_ready.
  state_t           state;
  logic [WIDTH-1:0] acc_lo;
  logic [EXT-1:0]   acc_hi;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [WIDTH-1:0] sum_lo;
  logic             carry;
  logic             accept;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_lo),
    .b    (in_data),
    .s    (sum_lo),
    .cout (carry)
  );

  // in_ready is gated by rst so it drops while reset is asserted.
  assign in_ready  = (state != HOLD) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  assign out_sum   = {acc_hi, acc_lo};
  assign out_count = count;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc_lo <= '0;
      acc_hi <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_lo <= sum_lo;
            acc_hi <= acc_hi + EXT'(carry);
            if (carry && (&acc_hi)) ovf <= 1'b1;
            if (!(&count)) count <= count + CNT_W'(1);
            state <= in_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state  <= IDLE;
            acc_lo <= '0;
            acc_hi <= '0;
            count  <= '0;
            ovf    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_accum_stream.sv
// Directed bench for adder_accum_stream: frame table plus hand-written
// sequences for backpressure, in_valid gaps and asynchronous reset.
module tb_adder_accum_stream;

  localparam int WIDTH = 6;
  localparam int EXT   = 4;
  localparam int CNT_W = 5;
  localparam int ACC_W = WIDTH + EXT;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic [CNT_W-1:0]   out_count;
  logic               out_ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [ACC_W-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] rest;
    int               beats;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } vec_t;

  vec_t vecs[8];

  adder_accum_stream #(.WIDTH(WIDTH), .EXT(EXT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input logic [WIDTH-1:0] d, input logic last);
    check("beat_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [CNT_W-1:0] cnt,
                              input logic ovf);
    logic [ACC_W-1:0] exp_sum;
    exp_sum = exp_q.pop_front();
    check({name, "_valid"}, out_valid, 1);
    check({name, "_sum"},   out_sum, exp_sum);
    check({name, "_count"}, out_count, cnt);
    check({name, "_ovf"},   out_ovf, ovf);
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_released"}, out_valid, 0);
    check({name, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    vecs[0] = '{first: 6'd42, rest: 6'd0,  beats: 1,  sum: 10'd42,   cnt: 5'd1,  ovf: 1'b0};
    vecs[1] = '{first: 6'd63, rest: 6'd1,  beats: 2,  sum: 10'd64,   cnt: 5'd2,  ovf: 1'b0};
    vecs[2] = '{first: 6'd63, rest: 6'd63, beats: 17, sum: 10'd47,   cnt: 5'd17, ovf: 1'b1};
    vecs[3] = '{first: 6'd5,  rest: 6'd6,  beats: 2,  sum: 10'd11,   cnt: 5'd2,  ovf: 1'b0};
    vecs[4] = '{first: 6'd0,  rest: 6'd0,  beats: 1,  sum: 10'd0,    cnt: 5'd1,  ovf: 1'b0};
    vecs[5] = '{first: 6'd63, rest: 6'd63, beats: 16, sum: 10'd1008, cnt: 5'd16, ovf: 1'b0};
    vecs[6] = '{first: 6'd1,  rest: 6'd1,  beats: 40, sum: 10'd40,   cnt: 5'd31, ovf: 1'b0};
    vecs[7] = '{first: 6'd63, rest: 6'd63, beats: 31, sum: 10'd929,  cnt: 5'd31, ovf: 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum",       out_sum, 0);
    check("rst_count",     out_count, 0);
    check("rst_ovf",       out_ovf, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // frame table
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(vecs[v].sum);
      for (int k = 0; k < vecs[v].beats; k++) begin
        beat((k == 0) ? vecs[v].first : vecs[v].rest, (k == vecs[v].beats - 1));
        if (k != vecs[v].beats - 1) check("mid_frame_not_valid", out_valid, 0);
      end
      check_result($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].ovf);
      release_result($sformatf("vec%0d", v));
    end

    // single beat with out_ready already high: one cycle of valid, then idle
    out_ready = 1'b1;
    exp_q.push_back(10'd42);
    beat(6'd42, 1'b1);
    check_result("single_hot", 5'd1, 1'b0);
    tick();
    check("single_hot_idle", out_valid, 0);
    check("single_hot_cleared", out_sum, 0);
    out_ready = 1'b0;

    // backpressure: result held, input stalled while in_valid stays high
    exp_q.push_back(10'd11);
    beat(6'd5, 1'b0);
    beat(6'd6, 1'b1);
    in_valid = 1'b1;
    in_data  = 6'd9;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_valid",    out_valid, 1);
      check("bp_sum",      out_sum, 11);
      check("bp_count",    out_count, 2);
      tick();
    end
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_sum",   out_sum, 0);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.push_back(10'd9);
    check_result("bp_next", 5'd1, 1'b0);
    release_result("bp_next");

    // gaps: 40 beats of 1 with in_valid toggling, count saturates
    exp_q.push_back(10'd40);
    for (int c = 0; c < 80; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = (c % 2 == 0) ? 6'd1 : 6'd33;
      in_last  = (c == 78);
      tick();
      if (c < 78) check("gap_not_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("gaps", 5'd31, 1'b0);
    release_result("gaps");

    // async reset mid-frame
    beat(6'd10, 1'b0);
    beat(6'd20, 1'b0);
    check("pre_rst_sum", out_sum, 30);
    #2 rst = 1'b1;
    #1;
    check("arst_sum",      out_sum, 0);
    check("arst_count",    out_count, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_valid",    out_valid, 0);
    #1 rst = 1'b0;
    tick();
    exp_q.push_back(10'd3);
    beat(6'd3, 1'b1);
    check_result("after_arst", 5'd1, 1'b0);

    // async reset while a result is held drops it immediately
    #2 rst = 1'b1;
    #1;
    check("arst_hold_valid", out_valid, 0);
    check("arst_hold_sum",   out_sum, 0);
    #1 rst = 1'b0;
    tick();
    check("arst_hold_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
